// File: rtl/uart_bram_sequencer_pkg.sv
// Shared definitions for the UART/BRAM image sequencer: default geometry
// and the sequencer state encoding.
package uart_bram_sequencer_pkg;

  localparam int DEF_DEPTH  = 16;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_LOAD   = 3'd0,
    ST_FULL   = 3'd1,
    ST_D_RD   = 3'd2,
    ST_D_WAIT = 3'd3,
    ST_D_HOLD = 3'd4
  } state_t;

endpackage

// File: rtl/uart_bram_sequencer.sv
// Arbitrates the single BRAM port between image capture from UART RX,
// image streaming to UART TX and the switch-addressed LED readout.
// All BRAM port signals are registered: a decision made at a clock edge
// appears on the port during the following cycle, and read data returns
// one cycle after that.
module uart_bram_sequencer
  import uart_bram_sequencer_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_ferr,
  input  logic              dump_req,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [ADDR_W-1:0] user_addr,
  output logic [DATA_W-1:0] user_data,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wdata,
  input  logic [DATA_W-1:0] bram_rdata,
  output logic [ADDR_W:0]   wr_count,
  output logic              full,
  output logic              overflow,
  output logic              dump_done
);

  localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_M1  = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W-1:0] dump_ptr;
  logic              user_rd_issued;  // port currently carries a user read
  logic              user_rd_ready;   // bram_rdata currently holds user data

  logic              rx_ok;
  logic              do_write;
  logic              start_dump;
  logic              next_dump;
  logic              do_dump_rd;
  logic [ADDR_W-1:0] dump_rd_addr;

  assign wr_count = wr_ptr;
  assign full     = (wr_ptr == DEPTH_C);

  // Port request decode; clear suppresses both RX writes and dump reads
  always_comb begin
    rx_ok        = rx_valid & ~rx_ferr;
    do_write     = ~clear & (state == ST_LOAD) & rx_ok & (wr_ptr != DEPTH_C);
    start_dump   = ~clear & (state == ST_FULL) & dump_req;
    next_dump    = ~clear & (state == ST_D_HOLD) & tx_ready & (dump_ptr != LAST_ADDR);
    do_dump_rd   = start_dump | next_dump;
    dump_rd_addr = start_dump ? '0 : dump_ptr + 1'b1;
  end

  // Sequencer FSM: capture pointer, dump pointer and the TX handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_LOAD;
      wr_ptr    <= '0;
      dump_ptr  <= '0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      overflow  <= 1'b0;
      dump_done <= 1'b0;
    end else begin
      dump_done <= 1'b0;
      if (clear) begin
        wr_ptr   <= '0;
        overflow <= 1'b0;
        tx_valid <= 1'b0;
        state    <= ST_LOAD;
      end else begin
        if (rx_ok && (state != ST_LOAD)) overflow <= 1'b1;
        case (state)
          ST_LOAD: begin
            if (do_write) begin
              wr_ptr <= wr_ptr + 1'b1;
              if (wr_ptr == DEPTH_M1) state <= ST_FULL;
            end
          end
          ST_FULL: begin
            if (start_dump) begin
              dump_ptr <= '0;
              state    <= ST_D_RD;
            end
          end
          // the read issued on entry is on the port during this cycle
          ST_D_RD: state <= ST_D_WAIT;
          ST_D_WAIT: begin
            tx_data  <= bram_rdata;
            tx_valid <= 1'b1;
            state    <= ST_D_HOLD;
          end
          ST_D_HOLD: begin
            if (tx_ready) begin
              tx_valid <= 1'b0;
              if (dump_ptr == LAST_ADDR) begin
                dump_done <= 1'b1;
                state     <= ST_FULL;
              end else begin
                dump_ptr <= dump_ptr + 1'b1;
                state    <= ST_D_RD;
              end
            end
          end
          default: state <= ST_LOAD;
        endcase
      end
    end
  end

  // BRAM port mux (RX write > dump read > user read) and LED readout pipeline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bram_en        <= 1'b0;
      bram_we        <= 1'b0;
      bram_addr      <= '0;
      bram_wdata     <= '0;
      user_rd_issued <= 1'b0;
      user_rd_ready  <= 1'b0;
      user_data      <= '0;
    end else begin
      bram_en       <= 1'b1;
      user_rd_ready <= user_rd_issued;
      if (user_rd_ready) user_data <= bram_rdata;
      if (do_write) begin
        bram_we        <= 1'b1;
        bram_addr      <= wr_ptr[ADDR_W-1:0];
        bram_wdata     <= rx_data;
        user_rd_issued <= 1'b0;
      end else if (do_dump_rd) begin
        bram_we        <= 1'b0;
        bram_addr      <= dump_rd_addr;
        user_rd_issued <= 1'b0;
      end else begin
        bram_we        <= 1'b0;
        bram_addr      <= user_addr;
        user_rd_issued <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_bram_sequencer.sv
// Self-checking bench for uart_bram_sequencer with a behavioural BRAM,
// a write scoreboard and a TX byte scoreboard.
`timescale 1ns/1ps
module tb_uart_bram_sequencer;

  typedef struct {
    logic [4:0] addr;
    logic [7:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst, clear, rx_valid, rx_ferr, dump_req, tx_ready;
  logic [7:0] rx_data;
  logic [4:0] user_addr;
  logic [7:0] tx_data, user_data, bram_wdata;
  logic       tx_valid, bram_en, bram_we, full, overflow, dump_done;
  logic [4:0] bram_addr;
  logic [5:0] wr_count;
  logic [7:0] bram_rdata;
  logic [7:0] mem [0:31];

  logic [7:0] image [16] = '{8'd10, 8'd15, 8'd25, 8'd31, 8'd45, 8'd64, 8'd99, 8'd127,
                             8'd155, 8'd255, 8'd190, 8'd84, 8'd55, 8'd32, 8'd20, 8'd7};

  wr_t        wq[$];
  logic [7:0] txq[$];
  int         checks = 0;
  int         passes = 0;
  int         exp_ptr = 0;

  uart_bram_sequencer dut (
    .clk(clk), .rst(rst), .clear(clear), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ferr(rx_ferr), .dump_req(dump_req), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .user_addr(user_addr), .user_data(user_data),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .bram_rdata(bram_rdata), .wr_count(wr_count),
    .full(full), .overflow(overflow), .dump_done(dump_done)
  );

  always #7.5 clk = ~clk;

  // Behavioural single-port BRAM with registered read
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) mem[bram_addr] <= bram_wdata;
      else         bram_rdata     <= mem[bram_addr];
    end
  end

  // Write scoreboard: every BRAM write must match the oldest expected write
  always @(negedge clk) begin
    if (!rst && bram_en && bram_we) begin
      checks++;
      if (wq.size() == 0) begin
        $display("FAIL unexpected_write: got addr=%0d data=%0d, required no write", bram_addr, bram_wdata);
      end else begin
        wr_t e;
        e = wq.pop_front();
        if (bram_addr !== e.addr || bram_wdata !== e.data)
          $display("FAIL bram_write: got addr=%0d data=%0d, required addr=%0d data=%0d",
                   bram_addr, bram_wdata, e.addr, e.data);
        else passes++;
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic ferr, input bit expect_wr);
    @(posedge clk); #1;
    rx_valid = 1'b1; rx_data = d; rx_ferr = ferr;
    if (expect_wr) begin
      wq.push_back('{addr: 5'(exp_ptr), data: d});
      exp_ptr++;
    end
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_ferr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 0; rx_valid = 0; rx_ferr = 0; rx_data = 0;
    dump_req = 0; tx_ready = 0; user_addr = 0; bram_rdata = 0;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({tx_valid, tx_data, dump_done} !== 10'd0)
      $display("FAIL reset_tx: got valid=%0b data=%0d done=%0b, required 0", tx_valid, tx_data, dump_done);
    else passes++;
    checks++;
    if ({full, overflow, wr_count} !== 8'd0)
      $display("FAIL reset_status: got full=%0b ovf=%0b count=%0d, required 0", full, overflow, wr_count);
    else passes++;
    checks++;
    if ({bram_en, bram_we, bram_addr, bram_wdata} !== 15'd0)
      $display("FAIL reset_bram: got en=%0b we=%0b addr=%0d wdata=%0d, required 0", bram_en, bram_we, bram_addr, bram_wdata);
    else passes++;
    checks++;
    if (user_data !== 8'd0) $display("FAIL reset_user: got %0d, required 0", user_data);
    else passes++;
    @(posedge clk); #1 rst = 1'b0;
    exp_ptr = 0;
    $display("reset: released");
  endtask

  task automatic test_load();
    for (int i = 0; i < 16; i++) begin
      send_byte(image[i], 1'b0, 1'b1);
      if (i == 14) begin
        checks++;
        if (full !== 1'b0 || wr_count !== 6'd15)
          $display("FAIL load_15: got full=%0b count=%0d, required full=0 count=15", full, wr_count);
        else passes++;
      end
    end
    @(negedge clk);
    checks++;
    if (full !== 1'b1 || wr_count !== 6'd16 || overflow !== 1'b0)
      $display("FAIL load_16: got full=%0b count=%0d ovf=%0b, required 1/16/0", full, wr_count, overflow);
    else passes++;
    $display("load: 16 bytes sent, count=%0d full=%0b", wr_count, full);
  endtask

  task automatic test_overflow();
    send_byte(8'd1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (overflow !== 1'b1 || wr_count !== 6'd16)
      $display("FAIL overflow: got ovf=%0b count=%0d, required ovf=1 count=16", overflow, wr_count);
    else passes++;
    $display("overflow: ovf=%0b count=%0d", overflow, wr_count);
  endtask

  // Runs a dump; accepts stop_after bytes with a busy_cycles TX model
  task automatic run_dump(input int busy_cycles, input int stop_after);
    int lat, accepted, busy, done_cnt, cyc;
    bit stable;
    logic [7:0] held, e;
    txq.delete();
    for (int i = 0; i < 16; i++) txq.push_back(image[i]);
    @(posedge clk); #1 dump_req = 1'b1;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) dump_req = 1'b0;
      if (tx_valid) break;
    end
    checks++;
    if (lat !== 3) $display("FAIL dump_latency: got %0d cycles, required 3", lat);
    else passes++;
    accepted = 0; busy = 0; done_cnt = 0; cyc = 0; stable = 1; held = 0;
    while (accepted < stop_after && cyc < 600) begin
      @(negedge clk);
      cyc++;
      if (dump_done) done_cnt++;
      if (tx_ready) begin
        tx_ready = 1'b0; busy = 0; accepted++;
        e = txq.pop_front();
        checks++;
        if (held !== e || !stable || tx_valid !== 1'b0)
          $display("FAIL dump_byte%0d: got %0d stable=%0b valid_after=%0b, required %0d stable=1 valid_after=0",
                   accepted - 1, held, stable, tx_valid, e);
        else passes++;
        $display("dump: byte %0d accepted = %0d", accepted - 1, held);
      end else if (tx_valid) begin
        if (busy == 0) begin held = tx_data; stable = 1; end
        else if (tx_data !== held) stable = 0;
        busy++;
        if (busy >= busy_cycles) tx_ready = 1'b1;
      end else if (busy > 0) begin
        stable = 0;
      end
    end
    if (accepted < stop_after) begin
      checks++;
      $display("FAIL dump_timeout: got %0d bytes, required %0d", accepted, stop_after);
    end
    if (stop_after == 16) begin
      repeat (3) begin
        @(negedge clk);
        if (dump_done) done_cnt++;
      end
      checks++;
      if (done_cnt !== 1) $display("FAIL dump_done: got %0d pulses, required 1", done_cnt);
      else passes++;
    end
  endtask

  task automatic test_dump();
    run_dump(10, 16);
  endtask

  task automatic test_user_read();
    int addrs [7] = '{0, 1, 2, 3, 4, 5, 8};
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1 user_addr = 5'(addrs[i]);
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (user_data !== image[addrs[i]])
        $display("FAIL user_read a=%0d: got %0d, required %0d", addrs[i], user_data, image[addrs[i]]);
      else passes++;
      $display("user_read: addr=%0d data=%0d", addrs[i], user_data);
    end
  endtask

  task automatic test_dump_with_sweep();
    int addrs [7] = '{0, 1, 2, 3, 4, 5, 8};
    fork
      run_dump(10, 16);
      begin
        for (int i = 0; i < 7; i++) begin
          @(posedge clk); #1 user_addr = 5'(addrs[i]);
          repeat (5) @(posedge clk);
        end
      end
    join
  endtask

  task automatic test_ferr_clear();
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    exp_ptr = 0;
    @(negedge clk);
    checks++;
    if (wr_count !== 6'd0 || full !== 1'b0 || overflow !== 1'b0)
      $display("FAIL clear: got count=%0d full=%0b ovf=%0b, required 0/0/0", wr_count, full, overflow);
    else passes++;
    send_byte(8'hAA, 1'b1, 1'b0);
    send_byte(8'h55, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (wr_count !== 6'd1) $display("FAIL ferr_count: got %0d, required 1", wr_count);
    else passes++;
    @(posedge clk); #1 clear = 1'b1; rx_valid = 1'b1; rx_data = 8'h77;
    @(posedge clk); #1 clear = 1'b0; rx_valid = 1'b0;
    exp_ptr = 0;
    @(negedge clk);
    checks++;
    if (wr_count !== 6'd0) $display("FAIL clear_rx: got count=%0d, required 0", wr_count);
    else passes++;
    @(posedge clk); #1 user_addr = 5'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (user_data !== 8'h55) $display("FAIL ferr_mem0: got %0h, required 55", user_data);
    else passes++;
    @(posedge clk); #1 user_addr = 5'd1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (user_data !== image[1]) $display("FAIL ferr_mem1: got %0d, required %0d", user_data, image[1]);
    else passes++;
    $display("ferr_clear: count=%0d", wr_count);
  endtask

  task automatic test_rst_mid_dump();
    int n;
    for (int i = 0; i < 16; i++) send_byte(image[i], 1'b0, 1'b1);
    run_dump(2, 5);
    n = 0;
    while (!tx_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (tx_valid !== 1'b1) $display("FAIL rst_pre: got tx_valid=%0b, required 1", tx_valid);
    else passes++;
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({tx_valid, tx_data, dump_done, full, overflow, wr_count, bram_en, bram_we, user_data} !== 28'd0)
      $display("FAIL rst_async: got valid=%0b data=%0d count=%0d en=%0b user=%0d, required all 0",
               tx_valid, tx_data, wr_count, bram_en, user_data);
    else passes++;
    txq.delete();
    tx_ready = 1'b0;
    exp_ptr = 0;
    @(posedge clk); #1 rst = 1'b0;
    send_byte(8'hA5, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (wr_count !== 6'd1) $display("FAIL rst_restart: got count=%0d, required 1", wr_count);
    else passes++;
    $display("rst_mid_dump: restart count=%0d", wr_count);
  endtask

  initial begin
    test_reset();
    test_load();
    test_overflow();
    test_dump();
    test_user_read();
    test_dump_with_sweep();
    test_ferr_clear();
    test_rst_mid_dump();
    repeat (4) @(negedge clk);
    checks++;
    if (wq.size() !== 0) $display("FAIL pending_writes: got %0d, required 0", wq.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
